// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and types for the two-client BRAM port arbiter.
package bram_port_arbiter_pkg;

    localparam int CRED_W = 2;
    localparam logic [CRED_W-1:0] CRED_MAX = 2'd2;

    typedef logic client_id_t;

    // BRAM output register adds one cycle of read latency.
    function automatic int lat_of(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Two-entry fall-through response buffer for one client.
module bram_rsp_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_cnt;
    logic                  w_empty;
    logic                  w_store;
    logic                  w_deq;

    assign w_empty = (r_cnt == 2'd0);
    // Data arriving at an empty buffer is presented at once; it is kept
    // only if the client does not take it in the same cycle.
    assign w_store = i_push & !(w_empty & i_pop);
    assign w_deq   = i_pop & !w_empty;
    assign o_valid = !w_empty | i_push;
    assign o_rdata = w_empty ? i_wdata : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_store) begin
                r_wptr <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_store} - {1'b0, w_deq};
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port between two clients; read
// credits bound in-flight reads to the response buffer depth.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PIPELINED  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    localparam int LAT = lat_of(PIPELINED);

    logic [1:0]            w_valid;
    logic [1:0]            w_write;
    logic [1:0]            w_elig;
    logic [1:0]            w_gnt;
    logic [1:0]            w_rd;
    logic [1:0]            w_ret;
    logic [1:0]            w_push;
    logic [1:0]            w_fvalid;
    logic [1:0]            w_rsp_valid;
    logic [1:0]            w_rsp_ready;
    logic [DATA_WIDTH-1:0] w_rdata [2];
    logic [CRED_W-1:0]     r_cred [2];
    client_id_t            r_prio;
    logic [LAT-1:0]        r_trk_v;
    client_id_t            r_trk_id [LAT];
    logic                  w_cap_v;
    client_id_t            w_cap_id;

    assign w_valid     = {req1_valid, req0_valid};
    assign w_write     = {req1_write, req0_write};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    // Reads need a free credit; writes never produce a response.
    always_comb begin
        w_elig = 2'b00;
        for (int c = 0; c < 2; c++) begin
            w_elig[c] = w_valid[c] & (w_write[c] | (r_cred[c] != '0));
        end
    end

    assign w_gnt[0] = !RST & w_elig[0] & (!w_elig[1] | (r_prio == 1'b0));
    assign w_gnt[1] = !RST & w_elig[1] & (!w_elig[0] | (r_prio == 1'b1));
    assign w_rd     = w_gnt & ~w_write;

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    assign bram_en   = |w_gnt;
    assign bram_we   = |(w_gnt & w_write);
    assign bram_addr = w_gnt[1] ? req1_addr : req0_addr;
    assign bram_di   = w_gnt[1] ? req1_wdata : req0_wdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prio <= 1'b0;
        end else if (w_gnt[0]) begin
            r_prio <= 1'b1;
        end else if (w_gnt[1]) begin
            r_prio <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        for (int c = 0; c < 2; c++) begin
            if (RST) begin
                r_cred[c] <= CRED_MAX;
            end else if (w_rd[c] & !w_ret[c]) begin
                r_cred[c] <= r_cred[c] - CRED_W'(1);
            end else if (!w_rd[c] & w_ret[c]) begin
                r_cred[c] <= r_cred[c] + CRED_W'(1);
            end
        end
    end

    // In-flight reads travel alongside the BRAM read pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_trk_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_trk_id[i] <= 1'b0;
            end
        end else begin
            r_trk_v[0]  <= |w_rd;
            r_trk_id[0] <= w_rd[1];
            for (int i = 1; i < LAT; i++) begin
                r_trk_v[i]  <= r_trk_v[i-1];
                r_trk_id[i] <= r_trk_id[i-1];
            end
        end
    end

    assign w_cap_v  = r_trk_v[LAT-1];
    assign w_cap_id = r_trk_id[LAT-1];

    assign w_push[0] = !RST & w_cap_v & (w_cap_id == 1'b0);
    assign w_push[1] = !RST & w_cap_v & (w_cap_id == 1'b1);

    assign w_rsp_valid = w_fvalid & {2{!RST}};
    assign w_ret       = w_rsp_valid & w_rsp_ready;

    for (genvar c = 0; c < 2; c++) begin : g_fifo
        bram_rsp_fifo #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_fifo (
            .i_clk  (CLK),
            .i_rst  (RST),
            .i_push (w_push[c]),
            .i_wdata(bram_do),
            .i_pop  (w_ret[c]),
            .o_valid(w_fvalid[c]),
            .o_rdata(w_rdata[c])
        );
    end

    assign rsp0_valid = w_rsp_valid[0];
    assign rsp1_valid = w_rsp_valid[1];
    assign rsp0_rdata = w_rdata[0];
    assign rsp1_rdata = w_rdata[1];

endmodule
